ii_rect_sum: RTL and testbench

Rectangle-sum engine for the 160x120 integral image (II) produced by the capture stage and held in block RAM. Given a rectangle origin and size, it reads up to four II corners through a single synchronous read port and returns the pixel sum, computed as D − C − B + A. It sits directly downstream of the integral-image BRAM and serves the Haar feature evaluator.

---
 rtl/ii_rect_sum.sv | 187 ++++++++++++++++++
 tb/tb_ii_rect_sum.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ii_rect_sum.sv
// Rectangle-sum engine over the 160x120 integral-image BRAM: sum = D - C - B + A.
// Define II_RECT_BOUNDS_CHECK_EN to reject empty or out-of-image rectangles (err).
module ii_rect_sum #(
  parameter int unsigned II_WIDTH   = 160,
  parameter int unsigned II_HEIGHT  = 120,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        ov7670_pclk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [7:0]  w,
  input  logic [6:0]  h,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] sum,
  output logic        ii_rd_en,
  output logic [14:0] ii_rd_addr,
  input  logic [31:0] ii_rd_data
);

  if (RD_LATENCY < 1 || RD_LATENCY > 2 || II_WIDTH * II_HEIGHT > 32768) begin : g_param_check
    $error("ii_rect_sum: unsupported RD_LATENCY or image size");
  end

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]  x0_q, w_q;
  logic [6:0]  y0_q, h_q;
  logic [7:0]  x1, xm;
  logic [6:0]  y1, ym;
  logic [14:0] addr_d, addr_c, addr_b, addr_a;
  logic [14:0] addr_c_q, addr_b_q, addr_a_q;
  logic [2:0]  pend;
  logic        rd_neg;
  logic [RD_LATENCY-1:0] tag_vld, tag_neg;
  logic [31:0] acc, acc_upd;
  logic        reject, accept, early_pend;
  logic        c_en, b_en;

  function automatic logic [14:0] ii_addr(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] yy;
    yy = {8'd0, y};
    if (II_WIDTH == 160)
      return (yy << 7) + (yy << 5) + {7'd0, x};
    else
      return 15'(yy * 15'(II_WIDTH)) + {7'd0, x};
  endfunction

  assign x1 = x0_q + w_q - 8'd1;
  assign y1 = y0_q + h_q - 7'd1;
  assign xm = x0_q - 8'd1;
  assign ym = y0_q - 7'd1;

  assign addr_d = ii_addr(x1, y1);
  assign addr_c = ii_addr(xm, y1);
  assign addr_b = ii_addr(x1, ym);
  assign addr_a = ii_addr(xm, ym);

  assign c_en = (x0_q != 8'd0);
  assign b_en = (y0_q != 7'd0);

`ifdef II_RECT_BOUNDS_CHECK_EN
  assign reject = (w_q == 8'd0) || (h_q == 7'd0) ||
                  (({1'b0, x0_q} + {1'b0, w_q}) > 9'(II_WIDTH)) ||
                  (({2'b0, y0_q} + {2'b0, h_q}) > 9'(II_HEIGHT));
`else
  assign reject = 1'b0;
`endif

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy   = (state == S_CALC) || (state == S_ISSUE) || (state == S_DRAIN);
  assign done   = (state == S_DONE);

  // Only the last tag stage may still be in flight when DRAIN hands over to DONE.
  always_comb begin
    early_pend = 1'b0;
    for (int unsigned i = 0; i + 1 < RD_LATENCY; i++)
      early_pend = early_pend | tag_vld[i];
  end

  always_comb begin
    acc_upd = acc;
    if (tag_vld[RD_LATENCY-1])
      acc_upd = tag_neg[RD_LATENCY-1] ? (acc - ii_rd_data) : (acc + ii_rd_data);
  end

  // DONE accepts start directly so a request arriving alongside done is not lost.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  state_nxt = reject ? S_DONE : S_ISSUE;
      S_ISSUE: if (pend == 3'b000) state_nxt = S_DRAIN;
      S_DRAIN: if (!early_pend) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ov7670_pclk) begin
    if (rst) begin
      state      <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      addr_c_q   <= '0;
      addr_b_q   <= '0;
      addr_a_q   <= '0;
      pend       <= '0;
      rd_neg     <= 1'b0;
      ii_rd_en   <= 1'b0;
      ii_rd_addr <= '0;
      tag_vld    <= '0;
      tag_neg    <= '0;
      acc        <= '0;
      sum        <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;

      tag_vld[0] <= ii_rd_en;
      tag_neg[0] <= rd_neg;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_neg[i] <= tag_neg[i-1];
      end

      if (accept) begin
        x0_q <= x0;
        y0_q <= y0;
        w_q  <= w;
        h_q  <= h;
        acc  <= '0;
      end else begin
        acc <= acc_upd;
      end

      unique case (state)
        S_CALC: begin
          if (reject) begin
            sum <= '0;
            err <= 1'b1;
          end else begin
            ii_rd_en   <= 1'b1;
            ii_rd_addr <= addr_d;
            rd_neg     <= 1'b0;
            addr_c_q   <= addr_c;
            addr_b_q   <= addr_b;
            addr_a_q   <= addr_a;
            pend       <= {c_en & b_en, b_en, c_en};
          end
        end
        S_ISSUE: begin
          if (pend[0]) begin
            ii_rd_addr <= addr_c_q;
            rd_neg     <= 1'b1;
            pend[0]    <= 1'b0;
          end else if (pend[1]) begin
            ii_rd_addr <= addr_b_q;
            rd_neg     <= 1'b1;
            pend[1]    <= 1'b0;
          end else if (pend[2]) begin
            ii_rd_addr <= addr_a_q;
            rd_neg     <= 1'b0;
            pend[2]    <= 1'b0;
          end else begin
            ii_rd_en <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!early_pend) begin
            sum <= acc_upd;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ii_rect_sum.sv
// Scoreboard bench for ii_rect_sum: BRAM holds II(x,y) = p(x+1)(y+1), read latency 1.
module tb_ii_rect_sum;

  logic        ov7670_pclk = 1'b0;
  logic        rst, start;
  logic [7:0]  x0, w;
  logic [6:0]  y0, h;
  logic        busy, done, err;
  logic [31:0] sum;
  logic        ii_rd_en;
  logic [14:0] ii_rd_addr;
  logic [31:0] ii_rd_data = '0;
  logic [31:0] p = '0;

  ii_rect_sum #(.II_WIDTH(160), .II_HEIGHT(120), .RD_LATENCY(1)) dut (
    .ov7670_pclk(ov7670_pclk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h),
    .busy(busy), .done(done), .err(err), .sum(sum),
    .ii_rd_en(ii_rd_en), .ii_rd_addr(ii_rd_addr), .ii_rd_data(ii_rd_data)
  );

  always #5 ov7670_pclk = ~ov7670_pclk;

  int unsigned cyc = 0;
  always @(posedge ov7670_pclk) cyc <= cyc + 1;

  always @(posedge ov7670_pclk) begin
    if (ii_rd_en) begin
      int unsigned a, xx, yy;
      a  = 32'(ii_rd_addr);
      xx = a % 160;
      yy = a / 160;
      ii_rd_data <= p * (xx + 1) * (yy + 1);
    end
  end

  typedef struct {
    logic [31:0] sum;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  logic [14:0] addr_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned done_cnt = 0;
  int unsigned done_target = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge ov7670_pclk) begin
    if (ii_rd_en) begin
      if (addr_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: read of address %0d, none expected", ii_rd_addr);
      end else begin
        check("rd_addr", 32'(ii_rd_addr), 32'(addr_q.pop_front()));
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL done_unexpected: done with sum 0x%0h, none expected", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", sum, e.sum);
        check("err", 32'(err), 32'(e.err));
        check("done_cycle", cyc, e.due);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push_addrs(input int n, input logic [14:0] a0, input logic [14:0] a1,
                            input logic [14:0] a2, input logic [14:0] a3);
    if (n > 0) addr_q.push_back(a0);
    if (n > 1) addr_q.push_back(a1);
    if (n > 2) addr_q.push_back(a2);
    if (n > 3) addr_q.push_back(a3);
  endtask

  // Drives start for one cycle; returns the cyc value just after the accepting edge.
  task automatic pulse_start(input logic [7:0] xx, input logic [6:0] yy, input logic [7:0] ww,
                             input logic [6:0] hh, input logic [31:0] pp, output int unsigned e);
    @(negedge ov7670_pclk);
    p = pp; x0 = xx; y0 = yy; w = ww; h = hh; start = 1'b1;
    @(posedge ov7670_pclk);
    #1 start = 1'b0;
    e = cyc;
  endtask

  task automatic push_exp(input logic [31:0] s, input logic er, input int unsigned due);
    exp_t e;
    e.sum = s; e.err = er; e.due = due;
    exp_q.push_back(e);
    done_target++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && done_cnt < done_target; i++) @(negedge ov7670_pclk);
    if (done_cnt < done_target) begin
      n_checks++;
      $display("FAIL done_timeout: done count %0d, expected %0d", done_cnt, done_target);
      done_cnt = done_target;
    end
    @(negedge ov7670_pclk);
  endtask

  // Expected sum/err/latency come from hand computation of II(x,y) = p(x+1)(y+1).
  task automatic run_req(input logic [7:0] xx, input logic [6:0] yy, input logic [7:0] ww,
                         input logic [6:0] hh, input logic [31:0] pp, input logic [31:0] s,
                         input logic er, input int unsigned lat);
    int unsigned e;
    pulse_start(xx, yy, ww, hh, pp, e);
    push_exp(s, er, e + lat - 1);
    check("busy_calc", 32'(busy), 32'd1);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e;
    rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0;
    repeat (3) @(posedge ov7670_pclk);
    #1 rst = 1'b0;
    @(negedge ov7670_pclk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_rd_en", 32'(ii_rd_en), 32'd0);
    check("rst_rd_addr", 32'(ii_rd_addr), 32'd0);

    push_addrs(1, 15'd19199, 15'd0, 15'd0, 15'd0);
    run_req(8'd0, 7'd0, 8'd160, 7'd120, 32'd1, 32'd19200, 1'b0, 4);

    push_addrs(4, 15'd3697, 15'd3689, 15'd3057, 15'd3049);
    run_req(8'd10, 7'd20, 8'd8, 7'd4, 32'd15, 32'd480, 1'b0, 7);

    push_addrs(2, 15'd1123, 15'd643, 15'd0, 15'd0);
    run_req(8'd0, 7'd5, 8'd4, 7'd3, 32'd2, 32'd24, 1'b0, 5);

    push_addrs(4, 15'd485, 15'd484, 15'd325, 15'd324);
    run_req(8'd5, 7'd3, 8'd1, 7'd1, 32'd7, 32'd7, 1'b0, 7);

    push_addrs(4, 15'd19199, 15'd19198, 15'd19039, 15'd19038);
    run_req(8'd159, 7'd119, 8'd1, 7'd1, 32'd3, 32'd3, 1'b0, 7);

`ifdef II_RECT_BOUNDS_CHECK_EN
    run_req(8'd155, 7'd0, 8'd10, 7'd1, 32'd1, 32'd0, 1'b1, 2);
`else
    push_addrs(2, 15'd164, 15'd154, 15'd0, 15'd0);
    run_req(8'd155, 7'd0, 8'd10, 7'd1, 32'd1, 32'hFFFF_FF6F, 1'b0, 5);
`endif

    // Starts sampled at edges 0, 3 and 7: the middle one falls while busy.
    push_addrs(4, 15'd3697, 15'd3689, 15'd3057, 15'd3049);
    push_addrs(4, 15'd3697, 15'd3689, 15'd3057, 15'd3049);
    pulse_start(8'd10, 7'd20, 8'd8, 7'd4, 32'd15, e);
    push_exp(32'd480, 1'b0, e + 6);
    repeat (2) @(posedge ov7670_pclk);
    #1 start = 1'b1;
    @(posedge ov7670_pclk);
    #1 start = 1'b0;
    check("busy_ignored_start", 32'(busy), 32'd1);
    repeat (3) @(posedge ov7670_pclk);
    #1 start = 1'b1;
    check("done_with_start", 32'(done), 32'd1);
    push_exp(32'd480, 1'b0, e + 13);
    @(posedge ov7670_pclk);
    #1 start = 1'b0;
    wait_done();

    // Reset sampled at edge 3: D and C have been issued, no done may follow.
    push_addrs(2, 15'd3697, 15'd3689, 15'd0, 15'd0);
    pulse_start(8'd10, 7'd20, 8'd8, 7'd4, 32'd15, e);
    repeat (2) @(posedge ov7670_pclk);
    #1 rst = 1'b1;
    @(posedge ov7670_pclk);
    #1 rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_sum", sum, 32'd0);
    check("rst_mid_addr_q", 32'(addr_q.size()), 32'd0);
    push_addrs(2, 15'd1123, 15'd643, 15'd0, 15'd0);
    run_req(8'd0, 7'd5, 8'd4, 7'd3, 32'd2, 32'd24, 1'b0, 5);

    repeat (10) @(negedge ov7670_pclk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
